// File: rtl/fp32_add_post.sv
// fp32_add_post: result stage behind the combinational fp32 adder.
// Stage 1 registers the operands, the raw sum and the tag, and classifies each operand.
// Stage 2 applies the special-value, cancellation, overflow and underflow overrides.
// It raises the {NV, OF, UF} flags and holds the result behind a valid/ready handshake.
// Define FP32_ADD_POST_STATS_EN to build the saturating per-flag event counters.
// When the macro is not defined, stat_*_cnt read as zero.
module fp32_add_post #(
    parameter int TAG_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_x,
    input  logic [31:0]       in_y,
    input  logic [31:0]       in_r,
    input  logic [TAG_W-1:0]  in_tag,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [31:0]       out_r,
    output logic [TAG_W-1:0]  out_tag,
    output logic [2:0]        out_flags,
    output logic [STAT_W-1:0] stat_nv_cnt,
    output logic [STAT_W-1:0] stat_of_cnt,
    output logic [STAT_W-1:0] stat_uf_cnt
);

    localparam logic [31:0] QNAN   = 32'h7FC0_0000;
    localparam logic [30:0] INF_MAG = 31'h7F80_0000;

    typedef struct packed {
        logic nan;
        logic snan;
        logic inf;
        logic zero;   // true zero or subnormal (flushed)
    } fp_class_t;

    function automatic fp_class_t classify(input logic [31:0] v);
        fp_class_t c;
        c.nan  = (v[30:23] == 8'hFF) && (v[22:0] != 23'd0);
        c.snan = c.nan && !v[22];
        c.inf  = (v[30:23] == 8'hFF) && (v[22:0] == 23'd0);
        c.zero = (v[30:23] == 8'h00);
        return c;
    endfunction

    // Pipeline state
    logic             r_s1_valid;
    logic [31:0]      r_s1_x;
    logic [31:0]      r_s1_y;
    logic [31:0]      r_s1_r;
    logic [TAG_W-1:0] r_s1_tag;
    fp_class_t        r_s1_xc;
    fp_class_t        r_s1_yc;
    logic [7:0]       r_s1_big_exp;
    logic             r_s1_eff_sub;

    logic             r_out_valid;
    logic [31:0]      r_out_r;
    logic [TAG_W-1:0] r_out_tag;
    logic [2:0]       r_out_flags;

    logic             w_en1;
    logic             w_en2;
    logic             w_accept;
    logic [31:0]      w_fix_r;
    logic [2:0]       w_fix_flags;
    logic [7:0]       w_r_exp;

    // A stage advances when it is empty or its contents move on this cycle.
    assign w_en2    = !r_out_valid || out_ready;
    assign w_en1    = !r_s1_valid || w_en2;
    assign w_accept = in_valid && w_en1;
    assign in_ready = w_en1;

    // Stage 1 occupancy; cleared asynchronously so in-flight beats are discarded on reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
        end else if (w_en1) begin
            // NOTE: non-blocking assignments on every register, so all stages sample pre-edge values.
            r_s1_valid <= in_valid;
        end
    end

    // Stage 1 payload: capture operands, raw sum, tag and the operand classification.
    // NOTE: payload registers carry no reset; r_s1_valid qualifies them, so stale contents are never used.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_s1_x       <= in_x;
            r_s1_y       <= in_y;
            r_s1_r       <= in_r;
            r_s1_tag     <= in_tag;
            r_s1_xc      <= classify(in_x);
            r_s1_yc      <= classify(in_y);
            r_s1_big_exp <= (in_x[30:23] > in_y[30:23]) ? in_x[30:23] : in_y[30:23];
            r_s1_eff_sub <= in_x[31] ^ in_y[31];
        end
    end

    assign w_r_exp = r_s1_r[30:23];

    // Priority fixup of the raw sum; the first matching case wins.
    always_comb begin
        // NOTE: defaults first, so every path assigns every output and no latch is inferred.
        w_fix_r     = r_s1_r;
        w_fix_flags = 3'b000;
        if (r_s1_xc.nan || r_s1_yc.nan) begin
            w_fix_r        = QNAN;
            w_fix_flags[2] = r_s1_xc.snan || r_s1_yc.snan;
        end else if (r_s1_xc.inf && r_s1_yc.inf && r_s1_eff_sub) begin
            w_fix_r        = QNAN;
            w_fix_flags[2] = 1'b1;
        end else if (r_s1_xc.inf) begin
            w_fix_r = r_s1_x;          // covers two same-signed infinities too
        end else if (r_s1_yc.inf) begin
            w_fix_r = r_s1_y;
        end else if (r_s1_xc.zero && r_s1_yc.zero) begin
            w_fix_r = {r_s1_x[31] & r_s1_y[31], 31'd0};
        end else if (r_s1_xc.zero) begin
            w_fix_r = r_s1_y;
        end else if (r_s1_yc.zero) begin
            w_fix_r = r_s1_x;
        end else if (r_s1_eff_sub && (r_s1_x[30:0] == r_s1_y[30:0])) begin
            w_fix_r = 32'd0;           // exact cancellation is +0 under round-to-nearest-even
        end else if ((w_r_exp == 8'hFF) || ((w_r_exp == 8'h00) && (r_s1_big_exp >= 8'hFE))) begin
            w_fix_r        = {r_s1_r[31], INF_MAG};
            w_fix_flags[1] = 1'b1;
        end else if ((w_r_exp == 8'h00) || (r_s1_eff_sub && (w_r_exp > r_s1_big_exp))) begin
            w_fix_r        = {r_s1_r[31], 31'd0};
            w_fix_flags[0] = 1'b1;
        end
    end

    // Output stage: loads on en2 and holds the current result while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_r     <= 32'd0;
            r_out_tag   <= '0;
            r_out_flags <= 3'b000;
        end else if (w_en2) begin
            r_out_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_out_r     <= w_fix_r;
                r_out_tag   <= r_s1_tag;
                r_out_flags <= w_fix_flags;
            end
        end
    end

    assign out_valid = r_out_valid;
    assign out_r     = r_out_r;
    assign out_tag   = r_out_tag;
    assign out_flags = r_out_flags;

`ifdef FP32_ADD_POST_STATS_EN
    logic              w_fire_out;
    logic [STAT_W-1:0] r_nv_cnt;
    logic [STAT_W-1:0] r_of_cnt;
    logic [STAT_W-1:0] r_uf_cnt;

    assign w_fire_out = r_out_valid && out_ready;

    // Saturating event counters, stepped once per flagged result handed to the consumer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_nv_cnt <= '0;
            r_of_cnt <= '0;
            r_uf_cnt <= '0;
        end else if (w_fire_out) begin
            if (r_out_flags[2] && (r_nv_cnt != {STAT_W{1'b1}})) r_nv_cnt <= r_nv_cnt + 1'b1;
            if (r_out_flags[1] && (r_of_cnt != {STAT_W{1'b1}})) r_of_cnt <= r_of_cnt + 1'b1;
            if (r_out_flags[0] && (r_uf_cnt != {STAT_W{1'b1}})) r_uf_cnt <= r_uf_cnt + 1'b1;
        end
    end

    assign stat_nv_cnt = r_nv_cnt;
    assign stat_of_cnt = r_of_cnt;
    assign stat_uf_cnt = r_uf_cnt;
`else
    assign stat_nv_cnt = '0;
    assign stat_of_cnt = '0;
    assign stat_uf_cnt = '0;
`endif

endmodule
